// File: rtl/drain_pkg.sv
// Shared constants and FSM state type for the result drain block.
package drain_pkg;
  localparam int NUM_PE = 16;
  localparam int IDX_W  = 4;
  localparam int TILE_W = 3;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;
endpackage

// File: rtl/drain_buffer.sv
// 16-entry capture register file: parallel load of all PE words, indexed read.
// Latency: load visible the cycle after the load edge; read is combinational.
module drain_buffer
  import drain_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     load,
  input  logic [NUM_PE*DATA_W-1:0] load_flat,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic [DATA_W-1:0]        rd_data
);

  // Contents are only meaningful after a load, so the storage carries no reset.
  logic [DATA_W-1:0] mem_q [NUM_PE];
  logic [DATA_W-1:0] mem_d [NUM_PE];

  always_comb begin
    for (int i = 0; i < NUM_PE; i++) begin
      mem_d[i] = load ? load_flat[i*DATA_W +: DATA_W] : mem_q[i];
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/result_drain.sv
// Captures 16 PE results on cap and streams them out one word per valid/ready beat; first
// beat valid 1 cycle after cap, words hold while stalled. DRAIN_RELU_EN clamps negatives.
module result_drain
  import drain_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cap,
  input  logic [NUM_PE*DATA_W-1:0] c_flat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [IDX_W-1:0]         out_idx,
  output logic [TILE_W-1:0]        out_tile,
  output logic                     out_last,
  output logic                     busy,
  output logic                     overrun,
  output logic                     drained
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TILE_W-1:0]   tile_q, tile_d;
  logic                overrun_q, overrun_d;
  logic                drained_q, drained_d;

  logic                     beat;
  logic                     final_beat;
  logic                     load;
  logic [NUM_PE*DATA_W-1:0] load_flat;
  logic [DATA_W-1:0]        rd_data;

  assign beat       = (state_q == ST_STREAM) && out_ready;
  assign final_beat = beat && (idx_q == IDX_W'(NUM_PE - 1));
  // The final-beat edge frees the buffer, so a cap there starts the next burst directly.
  assign load       = cap && ((state_q == ST_IDLE) || final_beat);

`ifdef DRAIN_RELU_EN
  always_comb begin
    load_flat = c_flat;
    for (int i = 0; i < NUM_PE; i++) begin
      if (c_flat[i*DATA_W + DATA_W - 1]) begin
        load_flat[i*DATA_W +: DATA_W] = '0;
      end
    end
  end
`else
  assign load_flat = c_flat;
`endif

  drain_buffer #(
    .DATA_W (DATA_W)
  ) u_buffer (
    .clk       (clk),
    .load      (load),
    .load_flat (load_flat),
    .rd_idx    (idx_q),
    .rd_data   (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tile_d    = tile_q;
    overrun_d = overrun_q;
    drained_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cap) begin
          state_d = ST_STREAM;
          idx_d   = '0;
        end
      end
      ST_STREAM: begin
        if (cap && !final_beat) begin
          overrun_d = 1'b1;
        end
        if (beat) begin
          if (final_beat) begin
            drained_d = 1'b1;
            tile_d    = tile_q + TILE_W'(1);
            idx_d     = '0;
            state_d   = cap ? ST_STREAM : ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      tile_q    <= '0;
      overrun_q <= 1'b0;
      drained_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tile_q    <= tile_d;
      overrun_q <= overrun_d;
      drained_q <= drained_d;
    end
  end

  assign out_valid = (state_q == ST_STREAM);
  assign busy      = out_valid;
  assign out_data  = out_valid ? rd_data : '0;
  assign out_idx   = idx_q;
  assign out_tile  = tile_q;
  assign out_last  = out_valid && (idx_q == IDX_W'(NUM_PE - 1));
  assign overrun   = overrun_q;
  assign drained   = drained_q;

endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench for result_drain: a burst-level model queues expected beats, a monitor checks them.
module tb_result_drain;
  localparam int DW  = 32;
  localparam int NPE = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cap;
  logic [NPE*DW-1:0] c_flat;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [3:0]        out_idx;
  logic [2:0]        out_tile;
  logic              out_last;
  logic              busy;
  logic              overrun;
  logic              drained;

  always #5 clk = ~clk;

  result_drain #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cap       (cap),
    .c_flat    (c_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_tile  (out_tile),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun),
    .drained   (drained)
  );

  typedef struct {
    logic [31:0] data;
    int          idx;
    int          tile;
    bit          last;
  } beat_t;

  beat_t exp_q[$];
  int    rd_ptr = 0;
  int    n_cmp  = 0;
  int    n_bad  = 0;

  // Reference model state: beats left in the current burst, tile counter, sticky flags.
  int    rem       = 0;
  int    m_tile    = 0;
  bit    m_overrun = 1'b0;
  bit    m_drained = 1'b0;

  int    rmode       = 0;
  bit    done        = 1'b0;
  int    timeout_cnt = 0;

  function automatic logic [31:0] expect_word(input logic [31:0] w);
`ifdef DRAIN_RELU_EN
    return w[31] ? 32'd0 : w;
`else
    return w;
`endif
  endfunction

  function automatic logic [NPE*DW-1:0] rand_flat();
    logic [NPE*DW-1:0] r;
    for (int i = 0; i < NPE; i++) r[i*DW +: DW] = $urandom;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem       = 0;
      m_tile    = 0;
      m_overrun = 1'b0;
      m_drained = 1'b0;
    end else begin
      bit beat_ok, fin, acc;
      beat_ok   = (rem > 0) && out_ready;
      fin       = beat_ok && (rem == 1);
      acc       = cap && ((rem == 0) || fin);
      m_drained = fin;
      if (cap && !acc) m_overrun = 1'b1;
      if (beat_ok) rem--;
      if (fin) m_tile = (m_tile + 1) % 8;
      if (acc) begin
        for (int i = 0; i < NPE; i++) begin
          exp_q.push_back('{data: expect_word(c_flat[i*DW +: DW]), idx: i, tile: m_tile, last: (i == NPE - 1)});
        end
        rem = NPE;
      end
    end
  end

  always begin
    @(negedge clk or posedge rst);
    if (rst) begin
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_last",  32'(out_last),  32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_overrun",   32'(overrun),   32'd0);
      chk("rst_drained",   32'(drained),   32'd0);
      chk("rst_out_data",  out_data,       32'd0);
      chk("rst_out_idx",   32'(out_idx),   32'd0);
      chk("rst_out_tile",  32'(out_tile),  32'd0);
      rd_ptr = exp_q.size();
    end else if (done) begin
      chk("wait_timeouts", 32'(timeout_cnt), 32'd0);
      chk("beats_left", 32'(exp_q.size() - rd_ptr), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end else begin
      chk("out_valid", 32'(out_valid), 32'(rem > 0));
      chk("busy",      32'(busy),      32'(rem > 0));
      chk("overrun",   32'(overrun),   32'(m_overrun));
      chk("drained",   32'(drained),   32'(m_drained));
      if (out_valid) begin
        if (rd_ptr < exp_q.size()) begin
          beat_t e;
          e = exp_q[rd_ptr];
          chk("out_data", out_data,      e.data);
          chk("out_idx",  32'(out_idx),  32'(e.idx));
          chk("out_tile", 32'(out_tile), 32'(e.tile));
          chk("out_last", 32'(out_last), 32'(e.last));
          if (out_ready) rd_ptr++;
        end else begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(1));
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic issue_cap(input logic [NPE*DW-1:0] d);
    c_flat = d;
    cap    = 1'b1;
    tick();
    cap    = 1'b0;
    c_flat = rand_flat();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (rem != 0 && n < 300) begin
      tick();
      n++;
    end
    if (rem != 0) timeout_cnt++;
    tick();
    tick();
  endtask

  task automatic wait_rem(input int target);
    int n;
    n = 0;
    while (rem != target && n < 100) begin
      tick();
      n++;
    end
    if (rem != target) timeout_cnt++;
  endtask

  initial begin
    logic [NPE*DW-1:0] d;
    rst       = 1'b0;
    cap       = 1'b0;
    out_ready = 1'b1;
    c_flat    = '0;
    #1;
    do_reset();

    for (int i = 0; i < NPE; i++) d[i*DW +: DW] = DW'(i * 100);
    issue_cap(d);
    wait_done();

    rmode = 1;
    issue_cap(rand_flat());
    wait_done();
    rmode = 0;

    issue_cap(rand_flat());
    wait_rem(11);
    issue_cap(rand_flat());
    wait_done();
    repeat (5) tick();
    do_reset();

    issue_cap(rand_flat());
    wait_rem(1);
    issue_cap(rand_flat());
    wait_done();
    do_reset();

    repeat (9) begin
      issue_cap(rand_flat());
      wait_done();
    end
    issue_cap(rand_flat());
    wait_rem(8);
    do_reset();
    repeat (3) tick();

    d = rand_flat();
    d[31:0]   = 32'hFFFF_FFF6;
    d[63:32]  = 32'h7FFF_FFFF;
    d[95:64]  = 32'h8000_0000;
    d[127:96] = 32'h0000_0000;
    issue_cap(d);
    wait_done();

    rmode = 2;
    repeat (400) begin
      if ($urandom_range(7) == 0) begin
        c_flat = rand_flat();
        cap    = 1'b1;
      end
      tick();
      cap = 1'b0;
    end
    rmode = 0;
    wait_done();

    done = 1'b1;
    repeat (20) @(posedge clk);
    $display("FAIL summary_not_reached");
    $fatal(1);
  end

endmodule
